// File: rtl/ctrl_ex_rd.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_ex_rd
//  Description : Execute-side read controller for the activation and weight
//                tile buffers. On an accepted tile start it latches the tile
//                sizes and walks the act x wgt read schedule. It drives the
//                buffer read enables and addresses and aligns valid/last
//                strobes to the buffer read latency for the BS and BP PE
//                arrays. It pulses ex_tile_end once the last read data of the
//                tile has been presented.
//
//  Ports
//    clk, rst_n           : clock, synchronous active-low reset
//    ex_tile_start        : start-of-tile pulse (ignored while busy)
//    bw_act_times         : activation words per tile
//    bs_bw_wgt_times      : bit-serial weight words per tile
//    bp_bw_wgt_times      : bit-parallel weight words per tile
//    ex_ready             : PE array can accept an issue this cycle
//    act_rd_en/_addr      : activation buffer read port
//    bs_wgt_rd_en/_addr   : BS weight buffer read port
//    bp_wgt_rd_en/_addr   : BP weight buffer read port
//    bs_rd_valid          : BS read data valid (issue delayed by RD_LAT)
//    bp_rd_valid          : BP read data valid (issue delayed by RD_LAT)
//    rd_last              : final issue of the tile, delayed by RD_LAT
//    ex_busy              : high from accepted start until ex_tile_end
//    ex_tile_end          : one-cycle end-of-tile pulse
//
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_ex_rd #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_tile_start,
    input  logic [ADDR_W-1:0] bw_act_times,
    input  logic [ADDR_W-1:0] bs_bw_wgt_times,
    input  logic [ADDR_W-1:0] bp_bw_wgt_times,
    input  logic              ex_ready,
    output logic              act_rd_en,
    output logic [ADDR_W-1:0] act_rd_addr,
    output logic              bs_wgt_rd_en,
    output logic [ADDR_W-1:0] bs_wgt_rd_addr,
    output logic              bp_wgt_rd_en,
    output logic [ADDR_W-1:0] bp_wgt_rd_addr,
    output logic              bs_rd_valid,
    output logic              bp_rd_valid,
    output logic              rd_last,
    output logic              ex_busy,
    output logic              ex_tile_end
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   C_ONE_EXT = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] C_INC     = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q;
    logic [ADDR_W-1:0] act_sz_q;
    logic [ADDR_W-1:0] bs_sz_q;
    logic [ADDR_W-1:0] bp_sz_q;
    logic [ADDR_W-1:0] wgt_sz_q;
    logic [ADDR_W-1:0] act_cnt_q;
    logic [ADDR_W-1:0] act_cnt_d;
    logic [ADDR_W-1:0] wgt_cnt_q;
    logic [ADDR_W-1:0] wgt_cnt_d;
    logic              busy_q;
    logic              tile_end_q;
    logic [RD_LAT-1:0] bs_pipe_q;
    logic [RD_LAT-1:0] bp_pipe_q;
    logic [RD_LAT-1:0] last_pipe_q;

    logic              w_issue;
    logic              w_act_wrap;
    logic              w_wgt_wrap;
    logic              w_last_issue;
    logic              w_bs_en;
    logic              w_bp_en;
    logic              w_last_to_out;
    logic              w_zero_size;
    logic [ADDR_W-1:0] w_wgt_sz_in;
    logic [ADDR_W:0]   w_act_max;
    logic [ADDR_W:0]   w_wgt_max;

    // Terminal counts are formed one bit wider so a zero size cannot wrap
    // around to an all-ones terminal count.
    assign w_act_max    = {1'b0, act_sz_q} - C_ONE_EXT;
    assign w_wgt_max    = {1'b0, wgt_sz_q} - C_ONE_EXT;
    assign w_act_wrap   = ({1'b0, act_cnt_q} == w_act_max);
    assign w_wgt_wrap   = ({1'b0, wgt_cnt_q} == w_wgt_max);

    assign w_issue      = (state_q == ST_RUN) && ex_ready;
    assign w_last_issue = w_issue && w_act_wrap && w_wgt_wrap;
    assign w_bs_en      = w_issue && (wgt_cnt_q < bs_sz_q);
    assign w_bp_en      = w_issue && (wgt_cnt_q < bp_sz_q);

    // The weight loop runs over the longer of the two weight streams; the
    // shorter stream simply has its enable masked for the tail words.
    assign w_wgt_sz_in  = (bs_bw_wgt_times >= bp_bw_wgt_times) ? bs_bw_wgt_times
                                                               : bp_bw_wgt_times;
    assign w_zero_size  = (bw_act_times == '0) || (w_wgt_sz_in == '0);

    // The FSM enters DONE on the same edge that presents rd_last, so the end
    // pulse follows rd_last by exactly one cycle. This looks at the value
    // about to be shifted into the final pipeline stage.
    if (RD_LAT == 1) begin : g_lat_one
        assign w_last_to_out = w_last_issue;
    end else begin : g_lat_multi
        assign w_last_to_out = last_pipe_q[RD_LAT-2];
    end

    always_comb begin
        act_cnt_d = act_cnt_q;
        wgt_cnt_d = wgt_cnt_q;
        if (w_issue) begin
            if (w_wgt_wrap) begin
                wgt_cnt_d = '0;
                // Activation counter parks on its last value after the final issue.
                if (!w_act_wrap) begin
                    act_cnt_d = act_cnt_q + C_INC;
                end
            end else begin
                wgt_cnt_d = wgt_cnt_q + C_INC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            act_sz_q   <= '0;
            bs_sz_q    <= '0;
            bp_sz_q    <= '0;
            wgt_sz_q   <= '0;
            act_cnt_q  <= '0;
            wgt_cnt_q  <= '0;
            busy_q     <= 1'b0;
            tile_end_q <= 1'b0;
        end else begin
            tile_end_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ex_tile_start) begin
                        act_sz_q  <= bw_act_times;
                        bs_sz_q   <= bs_bw_wgt_times;
                        bp_sz_q   <= bp_bw_wgt_times;
                        wgt_sz_q  <= w_wgt_sz_in;
                        act_cnt_q <= '0;
                        wgt_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= w_zero_size ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    act_cnt_q <= act_cnt_d;
                    wgt_cnt_q <= wgt_cnt_d;
                    if (w_last_issue) begin
                        state_q <= w_last_to_out ? ST_DONE : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_last_to_out) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    tile_end_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Buffer reads cannot be stalled, so this pipeline always advances;
    // a non-issue cycle simply inserts a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bs_pipe_q   <= '0;
            bp_pipe_q   <= '0;
            last_pipe_q <= '0;
        end else begin
            bs_pipe_q[0]   <= w_bs_en;
            bp_pipe_q[0]   <= w_bp_en;
            last_pipe_q[0] <= w_last_issue;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                bs_pipe_q[i]   <= bs_pipe_q[i-1];
                bp_pipe_q[i]   <= bp_pipe_q[i-1];
                last_pipe_q[i] <= last_pipe_q[i-1];
            end
        end
    end

    assign act_rd_en      = w_issue;
    assign act_rd_addr    = act_cnt_q;
    assign bs_wgt_rd_en   = w_bs_en;
    assign bs_wgt_rd_addr = wgt_cnt_q;
    assign bp_wgt_rd_en   = w_bp_en;
    assign bp_wgt_rd_addr = wgt_cnt_q;
    assign bs_rd_valid    = bs_pipe_q[RD_LAT-1];
    assign bp_rd_valid    = bp_pipe_q[RD_LAT-1];
    assign rd_last        = last_pipe_q[RD_LAT-1];
    assign ex_busy        = busy_q;
    assign ex_tile_end    = tile_end_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_ex_rd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctrl_ex_rd
//  Description : Self-checking bench for ctrl_ex_rd. Directed tiles followed
//                by randomized starts, sizes, ready patterns and resets,
//                checked every cycle against a tile-level reference model
//                (expanded issue list plus a latency-indexed valid schedule).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_ex_rd;

    localparam int ADDR_W = 16;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ex_tile_start = 1'b0;
    logic [ADDR_W-1:0] bw_act_times = '0;
    logic [ADDR_W-1:0] bs_bw_wgt_times = '0;
    logic [ADDR_W-1:0] bp_bw_wgt_times = '0;
    logic              ex_ready = 1'b0;
    logic              act_rd_en;
    logic [ADDR_W-1:0] act_rd_addr;
    logic              bs_wgt_rd_en;
    logic [ADDR_W-1:0] bs_wgt_rd_addr;
    logic              bp_wgt_rd_en;
    logic [ADDR_W-1:0] bp_wgt_rd_addr;
    logic              bs_rd_valid;
    logic              bp_rd_valid;
    logic              rd_last;
    logic              ex_busy;
    logic              ex_tile_end;

    always #5 clk = ~clk;

    ctrl_ex_rd #(
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex_tile_start   (ex_tile_start),
        .bw_act_times    (bw_act_times),
        .bs_bw_wgt_times (bs_bw_wgt_times),
        .bp_bw_wgt_times (bp_bw_wgt_times),
        .ex_ready        (ex_ready),
        .act_rd_en       (act_rd_en),
        .act_rd_addr     (act_rd_addr),
        .bs_wgt_rd_en    (bs_wgt_rd_en),
        .bs_wgt_rd_addr  (bs_wgt_rd_addr),
        .bp_wgt_rd_en    (bp_wgt_rd_en),
        .bp_wgt_rd_addr  (bp_wgt_rd_addr),
        .bs_rd_valid     (bs_rd_valid),
        .bp_rd_valid     (bp_rd_valid),
        .rd_last         (rd_last),
        .ex_busy         (ex_busy),
        .ex_tile_end     (ex_tile_end)
    );

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    typedef struct {
        int a;
        int w;
        bit bs;
        bit bp;
        bit last;
    } iss_t;

    iss_t iss_q[$];
    bit   sch_bs[16];
    bit   sch_bp[16];
    bit   sch_last[16];
    int   cyc = 0;
    int   checks = 0;
    int   errs = 0;
    bit   tile_active = 1'b0;
    bit   after_rst = 1'b0;
    int   end_cyc = -1;
    int   ready_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Per-cycle comparison, sampled mid-cycle (inputs change just after posedge).
    always @(negedge clk) begin : model
        iss_t e;
        bit   exp_iss;
        int   slot;
        int   sa;
        int   sw;
        int   ss;
        int   sp;
        slot    = cyc % 16;
        exp_iss = tile_active && (iss_q.size() > 0) && ex_ready;

        if (after_rst) begin
            check("rst_act_addr", act_rd_addr, 0);
            check("rst_bs_addr", bs_wgt_rd_addr, 0);
            check("rst_bp_addr", bp_wgt_rd_addr, 0);
            after_rst = 1'b0;
        end

        check("act_en", act_rd_en, exp_iss);
        if (exp_iss) begin
            e = iss_q.pop_front();
            check("act_addr", act_rd_addr, e.a);
            check("bs_addr", bs_wgt_rd_addr, e.w);
            check("bp_addr", bp_wgt_rd_addr, e.w);
            check("bs_en", bs_wgt_rd_en, e.bs);
            check("bp_en", bp_wgt_rd_en, e.bp);
            sch_bs[(cyc + RD_LAT) % 16]   = e.bs;
            sch_bp[(cyc + RD_LAT) % 16]   = e.bp;
            sch_last[(cyc + RD_LAT) % 16] = e.last;
            if (e.last) end_cyc = cyc + RD_LAT + 1;
        end else begin
            check("bs_en_idle", bs_wgt_rd_en, 0);
            check("bp_en_idle", bp_wgt_rd_en, 0);
            // Stalled mid-tile: the address shown is the next pending read.
            if (tile_active && iss_q.size() > 0) begin
                check("act_addr_hold", act_rd_addr, iss_q[0].a);
                check("wgt_addr_hold", bs_wgt_rd_addr, iss_q[0].w);
            end
        end

        check("bs_valid", bs_rd_valid, sch_bs[slot]);
        check("bp_valid", bp_rd_valid, sch_bp[slot]);
        check("rd_last", rd_last, sch_last[slot]);
        sch_bs[slot]   = 1'b0;
        sch_bp[slot]   = 1'b0;
        sch_last[slot] = 1'b0;

        check("busy", ex_busy, tile_active && (cyc != end_cyc));
        check("tile_end", ex_tile_end, cyc == end_cyc);
        if (cyc == end_cyc) begin
            tile_active = 1'b0;
            end_cyc     = -1;
        end

        if (!rst_n) begin
            iss_q.delete();
            for (int i = 0; i < 16; i++) begin
                sch_bs[i]   = 1'b0;
                sch_bp[i]   = 1'b0;
                sch_last[i] = 1'b0;
            end
            tile_active = 1'b0;
            end_cyc     = -1;
            after_rst   = 1'b1;
        end else if (ex_tile_start && !tile_active) begin
            sa = int'(bw_act_times);
            ss = int'(bs_bw_wgt_times);
            sp = int'(bp_bw_wgt_times);
            sw = (ss > sp) ? ss : sp;
            tile_active = 1'b1;
            if (sa == 0 || sw == 0) begin
                end_cyc = cyc + 2;
            end else begin
                for (int ai = 0; ai < sa; ai++) begin
                    for (int wi = 0; wi < sw; wi++) begin
                        e.a    = ai;
                        e.w    = wi;
                        e.bs   = (wi < ss);
                        e.bp   = (wi < sp);
                        e.last = (ai == sa - 1) && (wi == sw - 1);
                        iss_q.push_back(e);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : ready_drv
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       ex_ready = 1'b1;
                1:       ex_ready = ~ex_ready;
                default: ex_ready = ($urandom % 4) != 0;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_tile(input int a, input int s, input int p);
        ex_tile_start   = 1'b1;
        bw_act_times    = a[ADDR_W-1:0];
        bs_bw_wgt_times = s[ADDR_W-1:0];
        bp_bw_wgt_times = p[ADDR_W-1:0];
        step();
        ex_tile_start   = 1'b0;
        // Size inputs are only meaningful on an accepted start.
        bw_act_times    = ADDR_W'($urandom);
        bs_bw_wgt_times = ADDR_W'($urandom);
        bp_bw_wgt_times = ADDR_W'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (tile_active && n < budget) begin
            step();
            n++;
        end
        check("idle_timeout", tile_active, 0);
    endtask

    task automatic wait_end_cycle(input int budget);
        int n;
        n = 0;
        while (end_cyc != cyc && n < budget) begin
            step();
            n++;
        end
        check("end_wait_timeout", end_cyc == cyc, 1);
    endtask

    initial begin : main
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_mode = 0;
        step();

        start_tile(2, 3, 1);
        wait_idle(100);

        ready_mode = 1;
        start_tile(2, 3, 1);
        wait_idle(100);

        ready_mode = 0;
        start_tile(1, 0, 4);
        wait_idle(100);

        start_tile(0, 3, 3);
        wait_idle(100);
        start_tile(2, 0, 0);
        wait_idle(100);

        // Start while running is ignored; start on the end cycle is taken.
        start_tile(2, 3, 1);
        step();
        ex_tile_start   = 1'b1;
        bw_act_times    = 16'd5;
        bs_bw_wgt_times = 16'd5;
        bp_bw_wgt_times = 16'd5;
        step();
        ex_tile_start   = 1'b0;
        wait_end_cycle(100);
        start_tile(1, 2, 2);
        wait_idle(100);

        // Reset after three issues, then a fresh tile.
        start_tile(2, 3, 1);
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        start_tile(2, 3, 1);
        wait_idle(100);

        // Randomized traffic.
        ready_mode = 2;
        for (int i = 0; i < 600; i++) begin
            ex_tile_start   = ($urandom % 5) == 0;
            bw_act_times    = ADDR_W'($urandom_range(0, 3));
            bs_bw_wgt_times = ADDR_W'($urandom_range(0, 4));
            bp_bw_wgt_times = ADDR_W'($urandom_range(0, 4));
            rst_n           = ($urandom % 200) != 0;
            step();
        end
        ex_tile_start = 1'b0;
        rst_n         = 1'b1;
        wait_idle(300);

        repeat (4) step();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ctrl_ex_rd.md
Name: ctrl_ex_rd

Overview:
- Execute-side read controller for the activation and weight tile buffers that the load controller fills.
- On `ex_tile_start` it latches the tile sizes, then walks the act × wgt read schedule, driving buffer read enables and addresses.
- It aligns a valid/last strobe to the buffer read latency for the bit-parallel (BP) and bit-serial (BS) PE arrays.
- It pulses `ex_tile_end` when the last read data of the tile has been presented.

Parameters:
- ADDR_W, 16, width of every buffer read address and tile-size input.
- RD_LAT, 2, buffer read latency in cycles (1..4); the valid/last pipeline depth.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, synchronous active-low reset.
- ex_tile_start, input, 1, start-of-tile pulse; ignored while busy.
- bw_act_times, input, ADDR_W, activation words per tile; sampled on accepted start.
- bs_bw_wgt_times, input, ADDR_W, BS weight words per tile; sampled on accepted start.
- bp_bw_wgt_times, input, ADDR_W, BP weight words per tile; sampled on accepted start.
- ex_ready, input, 1, PE array can accept an issue this cycle.
- act_rd_en, output, 1, activation buffer read enable.
- act_rd_addr, output, ADDR_W, activation read address.
- bs_wgt_rd_en, output, 1, BS weight buffer read enable.
- bs_wgt_rd_addr, output, ADDR_W, BS weight read address.
- bp_wgt_rd_en, output, 1, BP weight buffer read enable.
- bp_wgt_rd_addr, output, ADDR_W, BP weight read address.
- bs_rd_valid, output, 1, BS data valid; issue delayed by RD_LAT.
- bp_rd_valid, output, 1, BP data valid; issue delayed by RD_LAT.
- rd_last, output, 1, marks the final issue of the tile, delayed by RD_LAT.
- ex_busy, output, 1, high from accepted start until `ex_tile_end`.
- ex_tile_end, output, 1, one-cycle end-of-tile pulse.

Behaviour:
- Reset: clk/rst_n synchronous active-low.
  - All outputs 0, state IDLE, counters 0, latched sizes 0.
  - A reset mid-tile aborts immediately; the valid/last pipeline is flushed.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On `ex_tile_start`, latch A=bw_act_times, S=bs_bw_wgt_times, P=bp_bw_wgt_times, W=max(S,P).
  - Clear act counter `a` and wgt counter `w`.
  - If A==0 or W==0, go to DONE; else go to RUN.
  - `ex_busy` rises the cycle after the start.
- RUN: an issue occurs in every cycle with `ex_ready`=1. No issue when `ex_ready`=0; addresses hold and enables are 0. On issue:
  - act_rd_en=1, act_rd_addr=a.
  - bs_wgt_rd_en=(w<S), bs_wgt_rd_addr=w.
  - bp_wgt_rd_en=(w<P), bp_wgt_rd_addr=w.
  - Rd enables are combinational from state, counters and `ex_ready`.
- Counter update, on issue only:
  - If w==W-1: w←0, and a←a+1 (or stay, see next item).
  - Issue with a==A-1 and w==W-1 is the last issue: it asserts the last flag, and the FSM goes to DRAIN.
  - Total issues per tile = A·W.
- Latency pipeline, RD_LAT-deep shift register carrying {bs_en, bp_en, last}:
  - bs_rd_valid / bp_rd_valid / rd_last appear exactly RD_LAT cycles after the issue cycle.
  - Stalls do not freeze the pipeline: buffer reads are not stallable, so a bubble simply enters it.
- DRAIN: wait until the last flag exits the pipeline (the cycle rd_last=1), then go to DONE.
- DONE: `ex_tile_end`=1 for exactly one cycle, `ex_busy`→0, then go to IDLE.
- Back-to-back tiles:
  - A start in the cycle `ex_tile_end`=1 is accepted (DONE→IDLE has priority; the start is sampled in IDLE the next cycle).
  - Minimum tile-to-tile gap: 1 cycle.
- `ex_tile_start` in RUN, DRAIN or DONE: ignored; latched sizes are unchanged.
- Widths:
  - Counters are ADDR_W bits.
  - Compares use A-1 and W-1 computed in ADDR_W+1 bits, so no underflow.
  - Sizes up to 2^ADDR_W-1 are supported.
- Zero-size tile: from start, DONE is reached next cycle; `ex_tile_end` is a single pulse 2 cycles after start, with no rd_en and no valid.

Test Plan:
- Reset, then A=2, S=3, P=1, RD_LAT=2, ex_ready=1.
  - 6 issues: act addr 0,0,0,1,1,1; bs addr 0,1,2,0,1,2 all enabled; bp_en only at w=0.
  - rd_last on the 6th valid, 2 cycles after the last issue.
  - ex_tile_end exactly 1 cycle after rd_last.
- Same tile with ex_ready toggling 1,0 every cycle: issue sequence identical, completes in 12 issue-window cycles.
  - Valids have gaps.
  - No address advances on ex_ready=0 cycles.
- A=1, S=0, P=4: bs_wgt_rd_en never asserts; bp addr 0..3; 4 bp_rd_valid pulses, 0 bs_rd_valid.
- Zero size (A=0 or S=P=0):
  - No enables or valids.
  - ex_tile_end single pulse 2 cycles after start.
  - ex_busy high for 1 cycle.
- Start pulse mid-RUN with different sizes: ignored; original 6-issue sequence completes unchanged.
  - Start asserted on the ex_tile_end cycle launches the next tile.
- rst_n low during RUN after 3 issues: all outputs 0 next cycle, no ex_tile_end.
  - A fresh start after reset runs from addr 0.
